// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC unit: PC register, memory request handshake,
// decode handshake, branch-condition evaluation, halt latch and a saturating
// retired-instruction counter.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INC      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  input  logic [2:0]        flags,
  input  logic [15:0]       br_reg_data,
  output logic              hlt,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED} state_e;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              hlt_q, hlt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              accept;
  logic              cond_true;
  logic [3:0]        opcode;
  logic signed [9:0] b_off10;
  logic [ADDR_W-1:0] b_off;
  logic [ADDR_W-1:0] pc_inc;
  logic              flag_z, flag_v, flag_n;

  assign accept  = (state_q == S_HOLD) & instr_valid_q & instr_ready;
  assign opcode  = instr_q[15:12];
  assign pc_inc  = pc_q + ADDR_W'(INC);
  // Word offset in halfword units; the signed cast sign-extends to ADDR_W.
  assign b_off10 = $signed({instr_q[8:0], 1'b0});
  assign b_off   = ADDR_W'(b_off10);
  assign flag_z  = flags[2];
  assign flag_v  = flags[1];
  assign flag_n  = flags[0];

  // Branch condition evaluated from instr[11:9] against the live flags
  always_comb begin
    cond_true = 1'b0;
    unique case (instr_q[11:9])
      3'b000: cond_true = ~flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = ~flag_z & ~flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z | (~flag_z & ~flag_n);
      3'b101: cond_true = flag_z | flag_n;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      hlt_q         <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      hlt_q         <= hlt_d;
      retired_q     <= retired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (imem_rdy) state_d = S_HOLD;
      S_HOLD:   if (accept) state_d = (opcode == OP_HLT) ? S_HALTED : S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath next values: capture on rdy, resolve next PC on accept
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    hlt_d         = hlt_q;
    retired_d     = retired_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_rdy) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (accept) begin
          if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
          instr_valid_d = 1'b0;
          if (opcode == OP_HLT)                hlt_d = 1'b1;
          else if (opcode == OP_B && cond_true)  pc_d = pc_inc + b_off;
          else if (opcode == OP_BR && cond_true) pc_d = br_reg_data[ADDR_W-1:0];
          else                                   pc_d = pc_inc;
        end
      end
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req = (state_q == S_FETCH);
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus     = pc_inc;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign hlt         = hlt_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a behavioural model of
// the next-PC rules. A narrow retired counter makes saturation reachable.
module tb_fetch_unit;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          imem_rdy = 1'b0;
  logic [15:0]   imem_rdata = '0;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [15:0]   pc, pc_plus;
  logic [2:0]    flags = '0;
  logic [15:0]   br_reg_data = '0;
  logic          hlt;
  logic [CW-1:0] retired;

  int ntest = 0;
  int nfail = 0;
  int mpc   = 0;
  int mret  = 0;
  bit mhlt  = 0;

  fetch_unit #(.ADDR_W(16), .INC(2), .RESET_PC(16'h0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus(pc_plus), .flags(flags), .br_reg_data(br_reg_data), .hlt(hlt),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_of(input int cc, input logic [2:0] fl);
    bit z, v, n;
    z = fl[2]; v = fl[1]; n = fl[0];
    case (cc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Reference: what the PC / counters become when word w is accepted
  task automatic model_accept(input logic [15:0] w, input logic [2:0] fl, input logic [15:0] br);
    int op, cc, simm;
    op = int'(w[15:12]);
    cc = int'(w[11:9]);
    simm = int'(w[8:0]);
    if (simm >= 256) simm -= 512;
    mret = (mret == CMAX) ? CMAX : mret + 1;
    if (op == 15) mhlt = 1;
    else if (op == 12 && cond_of(cc, fl)) mpc = (mpc + 2 + 2 * simm) & 32'hFFFF;
    else if (op == 13 && cond_of(cc, fl)) mpc = int'(br);
    else mpc = (mpc + 2) & 32'hFFFF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mpc = 0; mret = 0; mhlt = 0;
  endtask

  // One full fetch/decode round trip with chosen memory and decode stalls
  task automatic do_instr(input logic [15:0] w, input int rdy_wait, input int rdy_hold,
                          input logic [2:0] fl, input logic [15:0] br);
    for (int i = 0; i < rdy_wait; i++) begin
      imem_rdy = 1'b0;
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, mpc);
      step();
    end
    chk("req", imem_req, 1);
    chk("addr", imem_addr, mpc);
    imem_rdy = 1'b1;
    imem_rdata = w;
    step();
    imem_rdy = 1'b0;
    imem_rdata = $urandom;
    chk("hold_valid", instr_valid, 1);
    chk("hold_instr", instr, w);
    chk("hold_req", imem_req, 0);
    chk("hold_pc", pc, mpc);
    chk("hold_pc_plus", pc_plus, (mpc + 2) & 32'hFFFF);
    for (int i = 0; i < rdy_hold; i++) begin
      instr_ready = 1'b0;
      flags = 3'($urandom);
      step();
      chk("wait_valid", instr_valid, 1);
      chk("wait_instr", instr, w);
      chk("wait_pc", pc, mpc);
      chk("wait_ret", retired, mret);
      chk("wait_req", imem_req, 0);
    end
    instr_ready = 1'b1;
    flags = fl;
    br_reg_data = br;
    step();
    instr_ready = 1'b0;
    model_accept(w, fl, br);
    chk("acc_valid", instr_valid, 0);
    chk("acc_pc", pc, mpc);
    chk("acc_ret", retired, mret);
    chk("acc_hlt", hlt, mhlt);
    chk("acc_req", imem_req, mhlt ? 0 : 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_req", imem_req, 1);
    chk("rst_pc", pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_hlt", hlt, 0);
    chk("rst_ret", retired, 0);

    // Back-to-back sequential fetches
    for (int i = 0; i < 3; i++) do_instr(16'h0123, 0, 0, 3'b000, 16'h0000);
    chk("ret3", retired, 3);

    // Memory stall then decode stall at 0x0002
    do_reset();
    do_instr(16'h0123, 0, 0, 3'b000, 16'h0000);
    do_instr(16'h0123, 4, 3, 3'b000, 16'h0000);

    // B EQ taken / not taken, unconditional backward branch
    do_instr(16'hDE00, 0, 0, 3'b000, 16'h0010);
    do_instr(16'hC203, 0, 0, 3'b100, 16'h0000);
    chk("beq_taken", pc, 16'h0018);
    do_instr(16'hDE00, 0, 0, 3'b000, 16'h0010);
    do_instr(16'hC203, 0, 0, 3'b000, 16'h0000);
    chk("beq_not", pc, 16'h0012);
    do_instr(16'hDE00, 0, 0, 3'b000, 16'h0010);
    do_instr(16'hCFFF, 0, 0, 3'b000, 16'h0000);
    chk("b_back", pc, 16'h0010);

    // BR unconditional and BR LT not taken
    do_instr(16'hDE00, 0, 0, 3'b000, 16'h0ABC);
    chk("br_abs", pc, 16'h0ABC);
    do_instr(16'hD600, 0, 0, 3'b000, 16'h1234);
    chk("brlt_not", pc, 16'h0ABE);

    // PC wrap at the top of the address space
    do_instr(16'hDE00, 0, 0, 3'b000, 16'hFFFE);
    do_instr(16'h0123, 0, 1, 3'b000, 16'h0000);
    chk("wrap", pc, 16'h0000);

    // Randomized mix, HLT excluded; counter saturates on the way
    for (int k = 0; k < 40; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      case ($urandom_range(0, 2))
        0: w[15:12] = 4'hC;
        1: w[15:12] = 4'hD;
        default: if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      endcase
      do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 3'($urandom), 16'($urandom));
    end
    chk("ret_sat", retired, CMAX);

    // HLT at 0x0006: halts and stays quiet
    do_reset();
    do_instr(16'hDE00, 0, 0, 3'b000, 16'h0006);
    do_instr(16'hF000, 0, 0, 3'b000, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      imem_rdy = 1'b1;
      instr_ready = 1'b1;
      step();
      chk("halt_req", imem_req, 0);
      chk("halt_pc", pc, 16'h0006);
      chk("halt_hlt", hlt, 1);
      chk("halt_valid", instr_valid, 0);
    end
    imem_rdy = 1'b0;
    instr_ready = 1'b0;

    // Reset during a pending fetch discards the returning word
    do_reset();
    chk("unhalt", hlt, 0);
    do_instr(16'h0123, 0, 0, 3'b000, 16'h0000);
    chk("pre_rst_pc", pc, 16'h0002);
    imem_rdy = 1'b1;
    imem_rdata = 16'hF000;
    instr_ready = 1'b1;
    do_reset();
    imem_rdy = 1'b0;
    instr_ready = 1'b0;
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_ret", retired, 0);
    chk("mid_rst_req", imem_req, 1);
    do_instr(16'h0123, 1, 0, 3'b000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch and next-PC unit for the multi-cycle core. It merges the PC register, branch-condition evaluation and halt latch into one block. It also fetches from an instruction memory with a request/ready handshake, so memory latency is not fixed at one cycle. Fetched instructions go to decode through a valid/ready handshake, and the unit counts retired (accepted) instructions.

Parameters:
ADDR_W, 16, width of PC and instruction address.
INC, 2, PC increment per instruction (byte addressing).
RESET_PC, 0, PC value loaded on reset.
CNT_W, 32, width of retired-instruction counter (saturating).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
imem_req  output  1  fetch request; high exactly while state is FETCH.
imem_addr  output  ADDR_W  fetch address; equals pc, stable while imem_req is high.
imem_rdy  input  1  memory returns imem_rdata this cycle; ignored unless imem_req is high.
imem_rdata  input  16  instruction word.
instr  output  16  registered instruction presented to decode.
instr_valid  output  1  instr is valid.
instr_ready  input  1  decode accepts instr; accept = instr_valid & instr_ready.
pc  output  ADDR_W  address of the current/held instruction.
pc_plus  output  ADDR_W  pc + INC, modulo 2^ADDR_W (for PCS).
flags  input  3  {Z,V,N} from the flag register, sampled in the accept cycle.
br_reg_data  input  16  Rs value for BR, sampled in the accept cycle.
hlt  output  1  high once HLT has been accepted.
retired  output  CNT_W  number of accepted instructions, saturating at all-ones.

Behaviour:
- States: FETCH, HOLD, HALTED.
- Reset values (any edge with rst=1): state FETCH, pc=RESET_PC, instr=0, instr_valid=0, hlt=0, retired=0. imem_req is therefore 1 in the first cycle after reset. rst overrides every other input. An imem_rdy or accept in the rst cycle is discarded, and reset mid-fetch abandons the request.
- FETCH: imem_req=1, imem_addr=pc. On imem_rdy: instr<=imem_rdata, instr_valid<=1, go to HOLD. Without imem_rdy, hold the state with address unchanged. Only one request is outstanding at a time.
- HOLD: imem_req=0. instr, instr_valid and pc are held until accept. On accept:
  - retired increments unless it is all-ones.
  - Opcode is instr[15:12].
  - If opcode=1111 (HLT): go to HALTED, hlt<=1, instr_valid<=0, pc unchanged.
  - If opcode=1100 (B) and the condition is true: pc <= pc_plus + (sext(instr[8:0]) << 1), truncated to ADDR_W.
  - If opcode=1101 (BR) and the condition is true: pc <= br_reg_data[ADDR_W-1:0].
  - Otherwise: pc <= pc_plus.
  - For every non-HLT accept: instr_valid<=0, go to FETCH.
- Condition code instr[11:9]:
  - 000 NEQ Z=0.
  - 001 EQ Z=1.
  - 010 GT Z=0&N=0.
  - 011 LT N=1.
  - 100 GTE Z=1|(Z=0&N=0).
  - 101 LTE Z=1|N=1.
  - 110 OVFL V=1.
  - 111 unconditional.
- Condition decode applies only to opcodes 1100 and 1101. All other opcodes fall through to pc_plus.
- HALTED: no requests, instr_valid=0, pc frozen at the HLT address, hlt=1. Only rst leaves this state.
- Wrap-around: all PC arithmetic is modulo 2^ADDR_W, with no overflow detection.
- Throughput: at least 2 cycles per instruction (rdy in the request cycle, ready in the first HOLD cycle).
- Decode-to-fetch latency: the next imem_req is asserted in the cycle after accept.

Test Plan:
1. Reset, then imem_rdy=1 and instr_ready=1 constantly, memory returns 0x0123 -> imem_addr sequence 0x0000, 0x0002, 0x0004; instr_valid pulses every 2nd cycle; retired=3 after 3 accepts.
2. Memory stall of 4 cycles on rdy at pc 0x0002 -> imem_req stays high and imem_addr=0x0002 for 4 cycles. Then decode holds instr_ready low 3 cycles -> instr, pc and retired stable, imem_req=0.
3. B EQ (0xC203, imm=3) at pc 0x0010:
   - flags Z=1 -> next imem_addr 0x0018.
   - Same with Z=0 -> 0x0012.
   - 0xCFFF (unconditional, imm=-1) at 0x0010 -> 0x0010.
4. BR unconditional (0xDE00) with br_reg_data=0x0ABC -> next imem_addr 0x0ABC. BR LT with N=0 -> pc_plus.
5. Sequential instruction at pc 0xFFFE -> next imem_addr 0x0000, and pc_plus=0x0000 while holding.
6. HLT 0xF000 accepted at 0x0006 -> hlt=1 next cycle, pc=0x0006, no imem_req for 10 cycles. Pulse rst during a pending FETCH -> restart at RESET_PC, hlt=0, retired=0.
